// File: rtl/alu_mc_if.sv
// alu_mc_if: operation request/result handshake bundle for the multi-cycle ALU
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             zf;
  logic             cf;
  logic             of;
  modport master (output in_valid, op, a, b, out_ready, input in_ready, out_valid, f, zf, cf, of);
  modport slave (input in_valid, op, a, b, out_ready, output in_ready, out_valid, f, zf, cf, of);
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with single-cycle logic/arith/shift ops and iterative mul/div
module alu_mc #(parameter int WIDTH = 32) (
  input logic   clk,
  input logic   rst_n,
  alu_mc_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [2*WIDTH-1:0] p;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum, diff, m_sum, d_try;
  logic [2*WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] r_f, res;
  logic             r_cf, r_of, go_busy;
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};
  assign go_busy = bus.op >= 4'd11 && bus.op != 4'd15 && !(bus.op >= 4'd13 && bus.b == '0);
  always_comb begin
    r_f  = '0;
    r_cf = 1'b0;
    r_of = 1'b0;
    case (bus.op)
      4'd0:  r_f = bus.a & bus.b;
      4'd1:  r_f = bus.a | bus.b;
      4'd2:  r_f = bus.a ^ bus.b;
      4'd3:  r_f = ~(bus.a | bus.b);
      4'd4: begin
        r_f  = sum[WIDTH-1:0];
        r_cf = sum[WIDTH];
        r_of = bus.a[WIDTH-1] == bus.b[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
      end
      4'd5: begin
        r_f  = diff[WIDTH-1:0];
        r_cf = diff[WIDTH];
        r_of = bus.a[WIDTH-1] != bus.b[WIDTH-1] && diff[WIDTH-1] != bus.a[WIDTH-1];
      end
      4'd6:  r_f = WIDTH'(diff[WIDTH]);
      4'd7:  r_f = bus.b << bus.a;
      4'd8:  r_f = bus.b >> bus.a;
      4'd9:  r_f = $signed(bus.b) >>> bus.a;
      4'd10: r_f = WIDTH'($signed(bus.a) < $signed(bus.b));
      4'd13: begin
        r_f  = '1;
        r_of = 1'b1;
      end
      4'd14: begin
        r_f  = bus.a;
        r_of = 1'b1;
      end
      default: r_f = '0;
    endcase
  end
  // p holds {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide
  assign m_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, p[0] ? b_q : '0};
  assign d_try = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, b_q};
  assign p_nxt = op_q <= 4'd12 ? {m_sum, p[WIDTH-1:1]}
               : d_try[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
               : {d_try[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
  assign res = op_q[0] ? p_nxt[WIDTH-1:0] : p_nxt[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.f         <= '0;
      bus.zf        <= 1'b0;
      bus.cf        <= 1'b0;
      bus.of        <= 1'b0;
      op_q          <= '0;
      b_q           <= '0;
      p             <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          op_q         <= bus.op;
          b_q          <= bus.b;
          p            <= {{WIDTH{1'b0}}, bus.a};
          cnt          <= '0;
          bus.in_ready <= 1'b0;
          if (go_busy) state <= BUSY;
          else begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.f         <= r_f;
            bus.zf        <= r_f == '0;
            bus.cf        <= r_cf;
            bus.of        <= r_of;
          end
        end
        BUSY: begin
          p   <= p_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.f         <= res;
            bus.zf        <= res == '0;
            bus.cf        <= 1'b0;
            bus.of        <= 1'b0;
            cnt           <= '0;
          end
        end
        DONE: if (bus.out_ready) begin
          state         <= IDLE;
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table, directed corner sequences and random ops against a reference model
module tb_alu_mc;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_mc_if #(.WIDTH(W)) bus();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, f;
    logic [2:0]  fl;
    int          lat;
  } vec_t;
  vec_t vt[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic [3:0] op, input logic [31:0] a, b, f, input logic zf, cf, of, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.f = f; v.fl = {zf, cf, of}; v.lat = lat;
    vt.push_back(v);
  endtask
  function automatic void model(input logic [3:0] op, input logic [31:0] a, b,
                                output logic [31:0] f, output logic [2:0] fl, output int lat);
    longint s;
    longint unsigned u;
    logic c, o;
    c = 1'b0; o = 1'b0; f = '0; lat = 1;
    u = 64'(a) * 64'(b);
    case (op)
      4'd0: f = a & b;
      4'd1: f = a | b;
      4'd2: f = a ^ b;
      4'd3: f = ~(a | b);
      4'd4: begin
        u = 64'(a) + 64'(b); f = u[31:0]; c = u[32];
        s = longint'($signed(a)) + longint'($signed(b));
        o = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'd5: begin
        f = a - b; c = a < b;
        s = longint'($signed(a)) - longint'($signed(b));
        o = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      4'd6: f = (a < b) ? 32'd1 : 32'd0;
      4'd7: f = (a >= 32) ? 32'd0 : b << a[4:0];
      4'd8: f = (a >= 32) ? 32'd0 : b >> a[4:0];
      4'd9: f = (a >= 32) ? {32{b[31]}} : 32'($signed(b) >>> a[4:0]);
      4'd10: f = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd11: begin f = u[31:0]; lat = 33; end
      4'd12: begin f = u[63:32]; lat = 33; end
      4'd13: if (b == 0) begin f = '1; o = 1'b1; end else begin f = a / b; lat = 33; end
      4'd14: if (b == 0) begin f = a; o = 1'b1; end else begin f = a % b; lat = 33; end
      default: f = '0;
    endcase
    fl = {f == 0, c, o};
  endfunction
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, b,
                        output logic [31:0] f, output logic [2:0] fl, output int lat);
    int g = 0;
    while (!bus.in_ready && g < 100) begin @(posedge clk); #1; g++; end
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op = 4'($urandom); bus.a = $urandom; bus.b = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    f = bus.f; fl = {bus.zf, bus.cf, bus.of};
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] f, ef, hold, ra, rb;
    logic [2:0] fl, efl;
    logic [3:0] rop;
    int lat, elat;
    add(4'd4, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1, 0, 1);
    add(4'd4, 32'h7FFFFFFF, 32'd1, 32'h80000000, 0, 0, 1, 1);
    add(4'd5, 32'h80000000, 32'd1, 32'h7FFFFFFF, 0, 0, 1, 1);
    add(4'd5, 32'd1, 32'd2, 32'hFFFFFFFF, 0, 1, 0, 1);
    add(4'd7, 32'd4, 32'd1, 32'h10, 0, 0, 0, 1);
    add(4'd7, 32'd40, 32'd1, 32'd0, 1, 0, 0, 1);
    add(4'd9, 32'd4, 32'h80000000, 32'hF8000000, 0, 0, 0, 1);
    add(4'd9, 32'd40, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 1);
    add(4'd8, 32'd40, 32'hFFFFFFFF, 32'd0, 1, 0, 0, 1);
    add(4'd10, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 0, 0, 1);
    add(4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 0, 0, 1);
    add(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 33);
    add(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 0, 0, 0, 33);
    add(4'd13, 32'd100, 32'd7, 32'd14, 0, 0, 0, 33);
    add(4'd14, 32'd100, 32'd7, 32'd2, 0, 0, 0, 33);
    add(4'd13, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 0, 1, 1);
    add(4'd14, 32'd5, 32'd0, 32'd5, 0, 0, 1, 1);
    add(4'd3, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 1, 0, 0, 1);
    add(4'd15, 32'h12345678, 32'h9ABCDEF0, 32'd0, 1, 0, 0, 1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready_valid", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    check("reset_f", bus.f, 32'd0);
    check("reset_flags", 32'({bus.zf, bus.cf, bus.of}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, f, fl, lat);
      check($sformatf("vec%0d_f", i), f, vt[i].f);
      check($sformatf("vec%0d_flags", i), 32'(fl), 32'(vt[i].fl));
      check($sformatf("vec%0d_lat", i), lat, vt[i].lat);
    end
    // abort a multiply mid-flight; f must clear while the clock is between edges
    run_op(4'd4, 32'd1, 32'd2, f, fl, lat);
    bus.in_valid = 1'b1; bus.op = 4'd11; bus.a = 32'hDEADBEEF; bus.b = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready_valid", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    check("rst_mid_f", bus.f, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(4'd4, 32'd1, 32'd1, f, fl, lat);
    check("after_rst_add", f, 32'd2);
    bus.in_valid = 1'b1; bus.op = 4'd2; bus.a = 32'hF0F0F0F0; bus.b = 32'h0FF00FF0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_first", 32'({bus.out_valid, bus.in_ready}), 32'b10);
    hold = bus.f;
    check("bp_xor", hold, 32'hFF00FF00);
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1; bus.op = 4'd4; bus.a = $urandom; bus.b = $urandom;
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", k), {bus.f[29:0], bus.out_valid, bus.in_ready}, {hold[29:0], 2'b10});
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_release", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    check("bp_f_kept", bus.f, 32'hFF00FF00);
    for (int k = 0; k < 150; k++) begin
      rop = 4'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      model(rop, ra, rb, ef, efl, elat);
      run_op(rop, ra, rb, f, fl, lat);
      check($sformatf("rnd%0d_op%0d_f", k, rop), f, ef);
      check($sformatf("rnd%0d_op%0d_flags", k, rop), 32'(fl), 32'(efl));
      check($sformatf("rnd%0d_op%0d_lat", k, rop), lat, elat);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
